vector_crc_consumer: RTL and testbench
======================================

VECTOR_CRC_CONSUMER -- requirements
Module: vector_crc_consumer

Interface
REQ-001 Parameter FRAME_LEN, default 4: number of 8-bit vectors per frame; the range 1..255 SHALL be supported.
REQ-002 Parameter RETRY_MAX, default 15: number of consecutive empty responses allowed before a frame aborts; the range 1..255 SHALL be supported.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: begins one frame; it is sampled only in IDLE.
REQ-006 Port req, output, 1: pull request to the upstream vector buffer.
REQ-007 Port vector, input, 8: vector returned by upstream.
REQ-008 Port valid, input, 1: upstream response qualifier; vector is meaningful only while it is high.
REQ-009 Port busy, output, 1: high whenever the state is not IDLE.
REQ-010 Port done, output, 1: one-cycle pulse at frame completion.
REQ-011 Port error, output, 1: one-cycle pulse when a frame aborts after retries are exhausted.
REQ-012 Port crc, output, 8: frame CRC result.
REQ-013 Port count, output, 8: number of vectors consumed in the current or last frame.

Function
REQ-014 The block SHALL use states IDLE, REQ, WAIT and FIN, held in registers.
REQ-015 req SHALL be high exactly while the state is REQ, with at most one request outstanding.
REQ-016 Upstream response timing: a req sampled at edge N yields vector/valid visible in the cycle after edge N, and the block samples them at edge N+1.
REQ-017 IDLE transitions:
- start=1: go to REQ; clear the running CRC to 0x00; clear count and the retry counter.
- start=0: remain in IDLE.
REQ-018 REQ SHALL always go to WAIT after one cycle.
REQ-019 WAIT with valid=1:
- CRC_next = crc8(CRC ^ vector); count increments; the retry counter clears.
- If the new count equals FRAME_LEN, go to FIN; otherwise go to REQ.
REQ-020 WAIT with valid=0 (upstream empty):
- The retry counter increments.
- If the new retry value exceeds RETRY_MAX, go to IDLE and pulse error.
- Otherwise go to REQ without altering the CRC or count.
REQ-021 crc8 SHALL use polynomial 0x07, MSB-first, init 0x00, no reflection and no final XOR, computed over all 8 bits in a single cycle.
REQ-022 FIN SHALL pulse done for exactly one cycle, then go to IDLE.
REQ-023 The crc output SHALL show the running CRC at all times and hold it after done until the next accepted start.
REQ-024 The count output SHALL hold its value after a frame ends until the next accepted start.
REQ-025 start outside IDLE SHALL be ignored, including in the FIN cycle.
REQ-026 valid=1 arriving while not in WAIT (unsolicited) SHALL be ignored.
REQ-027 On abort, crc and count SHALL hold their partial values.
REQ-028 The count arithmetic width SHALL be 8 bits; FRAME_LEN=1 SHALL complete after a single accepted vector.

Reset
REQ-029 While rst=1 at an edge, the block SHALL enter IDLE.
REQ-030 During reset, req, done, error and busy SHALL all be 0.
REQ-031 During reset, crc SHALL be 0x00, count 0x00 and the retry counter 0.
REQ-032 rst SHALL take priority over start, valid and all state transitions.
REQ-033 rst asserted mid-frame SHALL abandon the frame with no done or error pulse; any response arriving after reset SHALL be ignored.

Verification
REQ-034 FRAME_LEN=9, upstream always valid, vectors ASCII "123456789" (0x31..0x39) -> single done pulse, crc=0xF4, count=9, req pulsed 9 times.
REQ-035 FRAME_LEN=2, vectors 0x01 then 0x00 -> crc reads 0x07 after the first, 0x15 at done; done occurs 5 cycles after the first req cycle (REQ,WAIT,REQ,WAIT,FIN).
REQ-036 FRAME_LEN=4, first two responses valid=0, then valid 0x01,0x00,0x00,0x00 -> retries absorbed, no error, count=4, done asserted once.
REQ-037 RETRY_MAX=3, upstream permanently empty -> after 4 empty WAITs, error pulses once, busy drops, count=0, crc=0x00.
REQ-038 rst pulsed during WAIT of the second vector -> next cycle is IDLE with crc=0x00 and count=0; a late valid=1 is ignored; start while busy has no effect.

Source files
------------

// File: rtl/vector_crc_consumer.sv
// vector_crc_consumer: pulls FRAME_LEN bytes, one request at a time, from an
// upstream vector buffer and folds each byte into a CRC-8 (poly 0x07, MSB-first,
// init 0x00). Empty responses are retried. After more than RETRY_MAX consecutive
// empties the frame aborts with an error pulse. All outputs are registered.
module vector_crc_consumer #(
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned RETRY_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       req,
    input  logic [7:0] vector,
    input  logic       valid,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] crc,
    output logic [7:0] count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);
    // The retry limit may be 255, so the incremented counter is compared with one spare bit.
    localparam logic [8:0] RETRY_MAX_W = 9'(RETRY_MAX);

    state_t     state_q, state_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] count_q, count_d;
    logic [7:0] retry_q, retry_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic [7:0] count_inc;
    logic [8:0] retry_inc;

    // One full byte of CRC-8 (poly 0x07) in a single cycle; data is crc^vector.
    function automatic logic [7:0] crc8_byte(input logic [7:0] data);
        logic [7:0] r;
        r = data;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        crc_d     = crc_q;
        count_d   = count_q;
        retry_d   = retry_q;
        error_d   = 1'b0;
        count_inc = count_q + 8'd1;
        retry_inc = {1'b0, retry_q} + 9'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    crc_d   = 8'h00;
                    count_d = 8'h00;
                    retry_d = 8'h00;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (valid) begin
                    crc_d   = crc8_byte(crc_q ^ vector);
                    count_d = count_inc;
                    retry_d = 8'h00;
                    state_d = (count_inc == FRAME_LEN_B) ? S_FIN : S_REQ;
                end else begin
                    // Empty response: CRC and count are untouched, even on abort.
                    retry_d = retry_inc[7:0];
                    if (retry_inc > RETRY_MAX_W) begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            crc_q   <= 8'h00;
            count_q <= 8'h00;
            retry_q <= 8'h00;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            count_q <= count_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign req   = req_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    assign crc   = crc_q;
    assign count = count_q;

endmodule

// File: tb/tb_vector_crc_consumer.sv
// Testbench for vector_crc_consumer: an upstream responder serves planned
// responses, a frame-level reference model predicts each frame's outcome into
// a scoreboard queue, and a monitor compares on every done/error pulse.
module tb_vector_crc_consumer;

    localparam int FRAME_LEN = 9;
    localparam int RETRY_MAX = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       req;
    logic [7:0] vector;
    logic       valid;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] crc;
    logic [7:0] count;

    vector_crc_consumer #(
        .FRAME_LEN (FRAME_LEN),
        .RETRY_MAX (RETRY_MAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .req    (req),
        .vector (vector),
        .valid  (valid),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .crc    (crc),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_done;
        logic [7:0] crc;
        logic [7:0] count;
        int         reqs;
        int         cycles;
    } exp_t;

    exp_t       sb_q[$];
    logic [8:0] resp_q[$];
    logic [7:0] frame_bytes[$];

    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_crc = 8'h00;
    logic [7:0] last_count = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC-8 as the remainder of (message * x^8) mod (x^8+x^2+x+1), message bits MSB-first.
    function automatic logic [7:0] ref_crc();
        logic [8:0] rem;
        logic [7:0] b;
        rem = 9'h000;
        for (int i = 0; i <= frame_bytes.size(); i++) begin
            b = (i < frame_bytes.size()) ? frame_bytes[i] : 8'h00;
            for (int k = 7; k >= 0; k--) begin
                rem = {rem[7:0], b[k]};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        end
        return rem[7:0];
    endfunction

    // Plan one frame's upstream responses and predict the frame outcome.
    task automatic build_frame(input int lead_empty, input int p_empty, input int abort_after,
                               output exp_t e);
        int         retry;
        int         reqs;
        logic       empty;
        logic [7:0] b;
        retry = 0;
        reqs  = 0;
        frame_bytes.delete();
        forever begin
            reqs++;
            empty = (reqs <= lead_empty) ||
                    (abort_after >= 0 && frame_bytes.size() >= abort_after) ||
                    ($urandom_range(99) < p_empty);
            if (empty) begin
                resp_q.push_back({1'b0, 8'($urandom)});
                retry++;
                if (retry > RETRY_MAX) begin
                    e.is_done = 1'b0;
                    break;
                end
            end else begin
                b = 8'($urandom);
                resp_q.push_back({1'b1, b});
                frame_bytes.push_back(b);
                retry = 0;
                if (frame_bytes.size() == FRAME_LEN) begin
                    e.is_done = 1'b1;
                    break;
                end
            end
        end
        e.crc    = ref_crc();
        e.count  = 8'(frame_bytes.size());
        e.reqs   = reqs;
        e.cycles = e.is_done ? 2 * reqs + 1 : 2 * reqs;
    endtask

    // Upstream buffer: answers a req seen at an edge during the following cycle;
    // in every other cycle it drives unsolicited junk that must be ignored.
    logic req_seen;
    always @(posedge clk) begin
        req_seen = req;
        #1;
        if (req_seen) begin
            if (resp_q.size() > 0) begin
                {valid, vector} = resp_q.pop_front();
            end else begin
                check("extra_req", 32'd1, 32'd0);
                valid  = 1'b0;
                vector = 8'h00;
            end
        end else begin
            valid  = ($urandom_range(3) == 0);
            vector = 8'($urandom);
        end
    end

    // Monitor: counts busy/req cycles per frame and scores each done/error pulse.
    int   mon_cyc = 0;
    int   mon_reqs = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (busy) mon_cyc++;
        if (req) mon_reqs++;
        if (done || error) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, done, error}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", {30'd0, done, error}, mon_e.is_done ? 32'd2 : 32'd1);
                check("frame_crc", {24'd0, crc}, {24'd0, mon_e.crc});
                check("frame_count", {24'd0, count}, {24'd0, mon_e.count});
                check("frame_reqs", mon_reqs, mon_e.reqs);
                check("frame_cycles", mon_cyc, mon_e.cycles);
            end
        end
        if (!busy) begin
            mon_cyc  = 0;
            mon_reqs = 0;
        end
    end

    // Run one planned frame; start is also pulsed while busy (including FIN) and must be ignored.
    task automatic run_frame(input exp_t e);
        bit fin;
        check("hold_crc", {24'd0, crc}, {24'd0, last_crc});
        check("hold_count", {24'd0, count}, {24'd0, last_count});
        sb_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        fin = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            start = done || ($urandom_range(3) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!fin) check("frame_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        check("idle_after_frame", {31'd0, busy}, 32'd0);
        check("end_crc", {24'd0, crc}, {24'd0, e.crc});
        check("end_count", {24'd0, count}, {24'd0, e.count});
        check("plan_consumed", resp_q.size(), 32'd0);
        last_crc   = e.crc;
        last_count = e.count;
    endtask

    // Abandon a frame by reset while waiting for its second vector.
    task automatic reset_mid_frame();
        exp_t e;
        bit   hit;
        build_frame(0, 0, -1, e);
        sb_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (busy && !req && count == 8'd1) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reached_second_wait", {31'd0, hit}, 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_crc", {24'd0, crc}, 32'd0);
        check("rst_count", {24'd0, count}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        resp_q.delete();
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("post_rst_crc", {24'd0, crc}, 32'd0);
        check("post_rst_count", {24'd0, count}, 32'd0);
        last_crc   = 8'h00;
        last_count = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst    = 1'b1;
        start  = 1'b0;
        valid  = 1'b0;
        vector = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req", {31'd0, req}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_crc", {24'd0, crc}, 32'd0);
        check("reset_count", {24'd0, count}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Check value "123456789": nine always-valid responses.
        for (int i = 0; i < 9; i++) resp_q.push_back({1'b1, 8'h31 + 8'(i)});
        e.is_done = 1'b1; e.crc = 8'hF4; e.count = 8'd9; e.reqs = 9; e.cycles = 19;
        run_frame(e);

        // Upstream permanently empty: abort after RETRY_MAX+1 empty waits, clears prior CRC.
        for (int i = 0; i < RETRY_MAX + 1; i++) resp_q.push_back({1'b0, 8'hA5});
        e.is_done = 1'b0; e.crc = 8'h00; e.count = 8'd0; e.reqs = 4; e.cycles = 8;
        run_frame(e);

        // Two leading empties are absorbed by retries.
        build_frame(2, 0, -1, e);
        run_frame(e);

        // Partial abort: crc and count keep the partial frame.
        build_frame(0, 20, 5, e);
        run_frame(e);

        reset_mid_frame();

        for (int f = 0; f < 30; f++) begin
            build_frame(0, 35, ($urandom_range(4) == 0) ? int'($urandom_range(FRAME_LEN - 1)) : -1, e);
            run_frame(e);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
